// File: rtl/fifo_read_streamer.sv
// Read side of an async FIFO: Gray/binary read pointer, empty flag and level,
// plus a 2-entry skid buffer that turns a registered-read memory into a valid/ready stream.
module fifo_read_streamer #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rclken,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] rdata,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [ADDRSIZE:0]   rlevel
);

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic [ADDRSIZE:0]   rlevel_q, rlevel_d;
  logic [ADDRSIZE:0]   wbin;
  logic                inflight_q;
  logic [1:0]          held_q, held_d;
  logic [DATASIZE-1:0] buf_q [2];
  logic [DATASIZE-1:0] buf_d [2];
  logic [2:0]          occ;
  logic [1:0]          wr_idx;
  logic                pop, issue;

  always_comb begin
    wbin = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign pop = (held_q != 2'd0) && m_ready;
  assign occ = 3'(held_q) + 3'(inflight_q);
  // Issue only if the word will still fit once the in-flight read lands.
  assign issue = !rrst && !rempty_q && (occ < (3'd2 + 3'(pop)));

  always_comb begin
    rbin_d   = rbin_q + (ADDRSIZE+1)'(issue);
    rptr_d   = rbin_d ^ (rbin_d >> 1);
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = wbin - rbin_d;
  end

  always_comb begin
    buf_d  = buf_q;
    held_d = held_q + 2'(inflight_q) - 2'(pop);
    wr_idx = held_q - 2'(pop);
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    // Capture lands behind whatever survives this cycle's pop, keeping order.
    if (inflight_q) begin
      buf_d[wr_idx[0]] = rdata;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      rlevel_q   <= '0;
      inflight_q <= 1'b0;
      held_q     <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      rlevel_q   <= rlevel_d;
      inflight_q <= issue;
      held_q     <= held_d;
    end
  end

  always_ff @(posedge rclk) begin
    buf_q <= buf_d;
  end

  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign rlevel  = rlevel_q;
  assign rclken  = issue;
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign m_valid = (held_q != 2'd0);
  assign m_data  = buf_q[0];

endmodule

// File: doc/fifo_read_streamer.md
FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 The module SHALL have parameter DATASIZE, default 8: width of each memory data word.
REQ-002 The module SHALL have parameter ADDRSIZE, default 4: number of memory address bits, so DEPTH = 2^ADDRSIZE.
REQ-003 The module SHALL have port rclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rrst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rq2_wptr, input, ADDRSIZE+1 bits: Gray-coded write pointer, already synchronized into rclk.
REQ-006 The module SHALL have port rptr, output, ADDRSIZE+1 bits: registered Gray-coded read pointer, sent to the write domain.
REQ-007 The module SHALL have port rempty, output, 1 bit: registered FIFO-empty flag.
REQ-008 The module SHALL have port rclken, output, 1 bit: read enable to a registered-read memory port.
REQ-009 The module SHALL have port raddr, output, ADDRSIZE bits: memory read address.
REQ-010 The module SHALL have port rdata, input, DATASIZE bits: memory read data, valid exactly one cycle after rclken.
REQ-011 The module SHALL have port m_valid, output, 1 bit: output stream word available.
REQ-012 The module SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-013 The module SHALL have port m_data, output, DATASIZE bits: output stream word.
REQ-014 The module SHALL have port rlevel, output, ADDRSIZE+1 bits: registered count of words in memory not yet issued.

Function
REQ-015 The module SHALL keep a binary read pointer rbin of ADDRSIZE+1 bits; raddr = rbin[ADDRSIZE-1:0]; rbin wraps modulo 2^(ADDRSIZE+1).
REQ-016 The module SHALL assert issue, driven combinationally on rclken, when !rempty and (held + inflight - pop) < 2, where held is buffer entries (0..2), inflight is an outstanding read (0..1), and pop = m_valid && m_ready.
REQ-017 On issue, rbin SHALL increment by 1, and rptr SHALL register gray(rbin_next) = rbin_next ^ (rbin_next >> 1).
REQ-018 rempty SHALL register (gray(rbin_next) == rq2_wptr) every cycle.
REQ-019 rlevel SHALL register bin(rq2_wptr) - rbin_next modulo 2^(ADDRSIZE+1); its range is 0..DEPTH.
REQ-020 inflight SHALL be set the cycle after issue and clear otherwise; rdata SHALL be captured into the 2-entry FIFO skid buffer at the end of the cycle in which inflight=1.
REQ-021 m_valid SHALL equal (held > 0), and m_data SHALL be the oldest buffered word, both held stable while m_valid && !m_ready.
REQ-022 Simultaneous capture and pop SHALL leave held unchanged and preserve word order.
REQ-023 Latency: rclken high in cycle T SHALL give m_valid high with that word in cycle T+2 when the buffer is otherwise empty.
REQ-024 With the memory non-empty and m_ready held at 1, the module SHALL sustain one word per cycle.
REQ-025 held SHALL never exceed 2, and no word SHALL be dropped or duplicated under any m_ready pattern.

Reset
REQ-026 When rrst=1 at an edge, the module SHALL set rbin=0, rptr=0, rempty=1, rlevel=0, inflight=0, held=0, and m_valid=0.
REQ-027 The reset values SHALL hold one cycle after rrst falls.
REQ-028 During reset, rclken SHALL be 0.
REQ-029 A reset asserted mid-stream SHALL discard buffered and in-flight words, with no m_valid in the following cycle.

Verification
REQ-030 Reset then rq2_wptr=0 -> rempty=1, rclken never 1, and m_valid=0 for 20 cycles.
REQ-031 rq2_wptr changed to gray(1)=1 at cycle 0 with m_ready=1 -> rempty=0 and rclken=1 with raddr=0 in cycle 1; m_valid=1 carrying mem[0] in cycle 3; rptr=1 and rempty=1 afterwards.
REQ-032 16 words written (rq2_wptr=gray(16)) and m_ready=1 -> 16 consecutive m_valid cycles with data in order 0..15, rptr ending at gray(16)=0x18, and rlevel stepping 15..0.
REQ-033 Same as REQ-032 but m_ready low for 5 cycles mid-stream -> held<=2, m_data stable while stalled, and no loss or duplication.
REQ-034 Wrap: 40 words pushed in bursts, rbin crossing 31->0 -> data order preserved and rempty correct at each wrap.
REQ-035 rrst pulsed while held=2 and inflight=1 -> next cycle m_valid=0, rptr=0, rempty=1.
